// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states, ALU op codes, condition codes and flag indices
package alu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_MI = 4'd2;
  localparam logic [3:0] COND_PL = 4'd3;
  localparam logic [3:0] COND_VS = 4'd4;
  localparam logic [3:0] COND_VC = 4'd5;
  localparam logic [3:0] COND_CS = 4'd6;
  localparam logic [3:0] COND_CC = 4'd7;
  localparam logic [3:0] COND_LT = 4'd8;
  localparam logic [3:0] COND_GE = 4'd9;
  localparam logic [3:0] COND_AL = 4'd10;
  localparam int N = 3;
  localparam int Z = 2;
  localparam int V = 1;
  localparam int C = 0;
endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: evaluates a condition code against stored {N,Z,V,C} flags
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);
  logic [15:0] tbl;
  always_comb begin
    tbl = {5'b0, 1'b1, ~(flags[N] ^ flags[V]), flags[N] ^ flags[V], ~flags[C], flags[C],
           ~flags[V], flags[V], ~flags[N], flags[N], ~flags[Z], flags[Z]};
    cond_true = tbl[cond];
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command/response controller driving an external ALU with accumulator and flags
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_src_acc,
  input  logic             cmd_wr_acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic [3:0]       rsp_nzvc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_result,
  input  logic [3:0]       alu_nzvc,
  output logic [W-1:0]     acc,
  output logic [3:0]       flags,
  input  logic [3:0]       cond,
  output logic             cond_true
);
  state_t state, state_nx;
  logic   wr_acc, accept;
  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
    accept    = cmd_ready && cmd_valid;
    state_nx  = accept ? EXEC : state == EXEC ? RESP : (rsp_valid && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      wr_acc     <= 1'b0;
      acc        <= '0;
      flags      <= '0;
      rsp_result <= '0;
      rsp_nzvc   <= '0;
    end else begin
      if (accept) begin
        alu_a   <= cmd_src_acc ? acc : cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_op;
        wr_acc  <= cmd_wr_acc;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_nzvc   <= alu_nzvc;
        flags      <= alu_nzvc;
        if (wr_acc) acc <= alu_result;
      end
    end
  end
  alu_cond_eval u_cond (
    .cond     (cond),
    .flags    (flags),
    .cond_true(cond_true)
  );
endmodule
